// File: rtl/load_unit_ctrl_if.sv
// Bundle of signals between the load controller, the decode/execute stage,
// the data memory read port and the register file write port.
// slave  : the load controller itself.
// master : everything around it (decode, memory, register file).
interface load_unit_ctrl_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_op;
    logic [4:0]  ld_rd;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        busy;
    logic        misalign;
    logic        timeout;

    modport slave (
        input  ld_valid, ld_addr, ld_op, ld_rd, mem_ack, mem_rdata,
        output ld_ready, mem_req, mem_addr, wb_en, wb_rd, wb_data,
               busy, misalign, timeout
    );

    modport master (
        output ld_valid, ld_addr, ld_op, ld_rd, mem_ack, mem_rdata,
        input  ld_ready, mem_req, mem_addr, wb_en, wb_rd, wb_data,
               busy, misalign, timeout
    );
endinterface

// File: rtl/load_unit_ctrl.sv
// load_unit_ctrl: single-outstanding load sequencer between decode and the
// data memory port. Checks alignment, issues a word read with req/ack,
// selects the byte/halfword lane, extends it and strobes the register file.
//
// Build option: define LDU_BACK2BACK_EN to let a new load be accepted in the
// writeback cycle, removing the idle bubble between consecutive loads.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a load; misaligned/illegal loads pulse misalign here
// S_REQ  | mem_req held until mem_ack or the request timer expires
// S_WB   | one cycle of register writeback (strobe suppressed for rd==0)
module load_unit_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    load_unit_ctrl_if.slave  bus
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    // Last REQ cycle index; an ack on this cycle still wins over the timeout.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] mem_addr_q;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q;
    logic [31:0] wb_data_q;
    logic        misalign_q;
    logic        timeout_q;

    logic        ld_bad;
    logic        cnt_expire;
    logic        ld_ready_c;
    logic        accept;
    logic        mem_req_c;
    logic        wb_en_c;
    logic        busy_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    // Classify the offered load: illegal opcode or an address that is not
    // naturally aligned for its size.
    always_comb begin
        ld_bad = 1'b1;
        case (bus.ld_op)
            OP_LB, OP_LBU: ld_bad = 1'b0;
            OP_LH, OP_LHU: ld_bad = bus.ld_addr[0];
            OP_LW:         ld_bad = |bus.ld_addr[1:0];
            default:       ld_bad = 1'b1;
        endcase
    end

    assign cnt_expire = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_d    = state_q;
        ld_ready_c = 1'b0;
        mem_req_c  = 1'b0;
        wb_en_c    = 1'b0;
        busy_c     = 1'b1;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_c     = 1'b0;
                ld_ready_c = 1'b1;
                accept     = bus.ld_valid;
                if (accept && !ld_bad) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack) begin
                    state_d = S_WB;
                end else if (cnt_expire) begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                wb_en_c = (rd_q != 5'd0);
                state_d = S_IDLE;
`ifdef LDU_BACK2BACK_EN
                ld_ready_c = 1'b1;
                accept     = bus.ld_valid;
                if (accept && !ld_bad) begin
                    state_d = S_REQ;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returning read word.
    always_comb begin
        byte_sel = bus.mem_rdata[7:0];
        case (lane_q)
            2'd0: byte_sel = bus.mem_rdata[7:0];
            2'd1: byte_sel = bus.mem_rdata[15:8];
            2'd2: byte_sel = bus.mem_rdata[23:16];
            2'd3: byte_sel = bus.mem_rdata[31:24];
            default: byte_sel = bus.mem_rdata[7:0];
        endcase
        half_sel = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        // op_q[2] marks the unsigned variants; op_q[1:0] encodes the size.
        case (op_q[1:0])
            2'b00:   ext_data = {{24{~op_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   ext_data = {{16{~op_q[2] & half_sel[15]}}, half_sel};
            default: ext_data = bus.mem_rdata;
        endcase
    end

    // Load latch, request timer, result capture and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q <= 32'd0;
            op_q       <= 3'd0;
            lane_q     <= 2'd0;
            rd_q       <= 5'd0;
            cnt_q      <= 8'd0;
            wb_data_q  <= 32'd0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            misalign_q <= accept && ld_bad;
            timeout_q  <= (state_q == S_REQ) && !bus.mem_ack && cnt_expire;

            if (accept && !ld_bad) begin
                mem_addr_q <= {bus.ld_addr[31:2], 2'b00};
                op_q       <= bus.ld_op;
                lane_q     <= bus.ld_addr[1:0];
                rd_q       <= bus.ld_rd;
            end

            // Timer counts REQ cycles and restarts from zero on every entry.
            if ((state_q == S_REQ) && (state_d == S_REQ)) begin
                cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= 8'd0;
            end

            if ((state_q == S_REQ) && bus.mem_ack) begin
                wb_data_q <= ext_data;
            end
        end
    end

    assign bus.ld_ready = ld_ready_c;
    assign bus.mem_req  = mem_req_c;
    assign bus.mem_addr = mem_addr_q;
    assign bus.wb_en    = wb_en_c;
    assign bus.wb_rd    = rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.busy     = busy_c;
    assign bus.misalign = misalign_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Directed bench for load_unit_ctrl: a vector table of single loads plus
// hand-written sequences for reset, stray acks and back-to-back loads.
module tb_load_unit_ctrl;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    load_unit_ctrl_if bus ();

    load_unit_ctrl #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          dly;    // REQ cycles without ack before ack; -1 = never
        int          mis;
        int          req;
        logic [31:0] maddr;
        int          wb;
        logic [31:0] wdata;
        int          to;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Offer one load for a single cycle, then watch a fixed window,
    // acking after dly REQ cycles.
    task automatic run_load(input logic [2:0] op, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input int dly,
                            output int n_mis, output int n_req, output int n_wb,
                            output int n_to, output logic rdy0,
                            output logic [31:0] maddr, output logic [31:0] wdata,
                            output logic [4:0] wrd);
        n_mis = 0; n_req = 0; n_wb = 0; n_to = 0; rdy0 = 1'b0;
        maddr = '0; wdata = '0; wrd = '0;
        bus.ld_op    = op;
        bus.ld_addr  = addr;
        bus.ld_rd    = rd;
        bus.ld_valid = 1'b1;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        for (int c = 0; c < 22; c++) begin
            bus.mem_ack = 1'b0;
            if (c == 0) rdy0 = bus.ld_ready;
            if (bus.misalign) n_mis++;
            if (bus.timeout) n_to++;
            if (bus.mem_req) begin
                n_req++;
                maddr = bus.mem_addr;
                if (dly >= 0 && n_req == dly + 1) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
            if (bus.wb_en) begin
                n_wb++;
                wdata = bus.wb_data;
                wrd   = bus.wb_rd;
            end
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_mis, n_req, n_wb, n_to;
        logic rdy0;
        logic [31:0] maddr, wdata;
        logic [4:0] wrd;
        int first_wb, second_req, n_rise, wb_total;
        logic prev_req;

        n_pass = 0;
        n_total = 0;

        //            op      addr          rd     rdata         dly mis req maddr         wb wdata         to
        vecs[0]  = '{3'b000, 32'h0000_1003, 5'd5,  32'h80AB_CDEF, 2, 0, 3,  32'h0000_1000, 1, 32'hFFFF_FF80, 0};
        vecs[1]  = '{3'b101, 32'h0000_2002, 5'd6,  32'h9234_5678, 0, 0, 1,  32'h0000_2000, 1, 32'h0000_9234, 0};
        vecs[2]  = '{3'b001, 32'h0000_2002, 5'd7,  32'h9234_5678, 1, 0, 2,  32'h0000_2000, 1, 32'hFFFF_9234, 0};
        vecs[3]  = '{3'b010, 32'h0000_2000, 5'd8,  32'h9234_5678, 0, 0, 1,  32'h0000_2000, 1, 32'h9234_5678, 0};
        vecs[4]  = '{3'b100, 32'h0000_1001, 5'd9,  32'h80AB_CDEF, 3, 0, 4,  32'h0000_1000, 1, 32'h0000_00CD, 0};
        vecs[5]  = '{3'b000, 32'h0000_1000, 5'd10, 32'h80AB_CDEF, 0, 0, 1,  32'h0000_1000, 1, 32'hFFFF_FFEF, 0};
        vecs[6]  = '{3'b001, 32'h0000_3000, 5'd11, 32'h1234_7FFF, 0, 0, 1,  32'h0000_3000, 1, 32'h0000_7FFF, 0};
        vecs[7]  = '{3'b000, 32'h0000_3002, 5'd12, 32'h1234_5678, 0, 0, 1,  32'h0000_3000, 1, 32'h0000_0034, 0};
        vecs[8]  = '{3'b001, 32'h0000_0001, 5'd1,  32'h0,         0, 1, 0,  32'h0,         0, 32'h0,         0};
        vecs[9]  = '{3'b011, 32'h0000_0000, 5'd1,  32'h0,         0, 1, 0,  32'h0,         0, 32'h0,         0};
        vecs[10] = '{3'b010, 32'h0000_2002, 5'd1,  32'h0,         0, 1, 0,  32'h0,         0, 32'h0,         0};
        vecs[11] = '{3'b111, 32'h0000_0004, 5'd1,  32'h0,         0, 1, 0,  32'h0,         0, 32'h0,         0};
        vecs[12] = '{3'b010, 32'h0000_0040, 5'd0,  32'h5555_AAAA, 0, 0, 1,  32'h0000_0040, 0, 32'h0,         0};
        vecs[13] = '{3'b010, 32'h0000_0050, 5'd3,  32'h0,        -1, 0, 16, 32'h0000_0050, 0, 32'h0,         1};
        vecs[14] = '{3'b010, 32'h0000_0060, 5'd4,  32'hDEAD_BEEF, 15, 0, 16, 32'h0000_0060, 1, 32'hDEAD_BEEF, 0};
        vecs[15] = '{3'b101, 32'h0000_0062, 5'd31, 32'hDEAD_BEEF, 0, 0, 1,  32'h0000_0060, 1, 32'h0000_DEAD, 0};

        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_op     = '0;
        bus.ld_rd     = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req",  32'(bus.mem_req),  32'd0);
        chk("rst_wb_en",    32'(bus.wb_en),    32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
        chk("rst_timeout",  32'(bus.timeout),  32'd0);
        chk("rst_mem_addr", bus.mem_addr,      32'd0);
        chk("rst_wb_rd",    32'(bus.wb_rd),    32'd0);
        chk("rst_wb_data",  bus.wb_data,       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            run_load(vecs[i].op, vecs[i].addr, vecs[i].rd, vecs[i].rdata, vecs[i].dly,
                     n_mis, n_req, n_wb, n_to, rdy0, maddr, wdata, wrd);
            chk($sformatf("v%0d_misalign", i), 32'(n_mis), 32'(vecs[i].mis));
            chk($sformatf("v%0d_ready_next", i), 32'(rdy0), 32'(vecs[i].mis));
            chk($sformatf("v%0d_req_cycles", i), 32'(n_req), 32'(vecs[i].req));
            chk($sformatf("v%0d_wb_cycles", i), 32'(n_wb), 32'(vecs[i].wb));
            chk($sformatf("v%0d_timeout", i), 32'(n_to), 32'(vecs[i].to));
            if (vecs[i].req > 0) chk($sformatf("v%0d_mem_addr", i), maddr, vecs[i].maddr);
            if (vecs[i].wb > 0) begin
                chk($sformatf("v%0d_wb_data", i), wdata, vecs[i].wdata);
                chk($sformatf("v%0d_wb_rd", i), 32'(wrd), 32'(vecs[i].rd));
            end
        end

        // Stray ack while idle must not start anything.
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("stray_ack_busy",    32'(bus.busy),    32'd0);
        chk("stray_ack_mem_req", 32'(bus.mem_req), 32'd0);
        chk("stray_ack_wb_en",   32'(bus.wb_en),   32'd0);

        // Asynchronous reset in the middle of REQ.
        bus.ld_op = 3'b010; bus.ld_addr = 32'h0000_0070; bus.ld_rd = 5'd2;
        bus.ld_valid = 1'b1;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        @(posedge clk); #1;
        chk("midreq_mem_req_before", 32'(bus.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreq_mem_req_async", 32'(bus.mem_req), 32'd0);
        chk("midreq_busy_async",    32'(bus.busy),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_wb = 0; n_req = 0;
        for (int c = 0; c < 6; c++) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = 32'hCAFE_F00D;
            if (bus.wb_en) n_wb++;
            if (bus.mem_req) n_req++;
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
        chk("midreq_no_wb_after",  32'(n_wb),  32'd0);
        chk("midreq_no_req_after", 32'(n_req), 32'd0);

        // Two lw loads with ld_valid held; memory acks immediately.
        bus.ld_op = 3'b010; bus.ld_addr = 32'h0000_0100; bus.ld_rd = 5'd9;
        bus.mem_rdata = 32'h1111_2222;
        bus.ld_valid = 1'b1;
        first_wb = -1; second_req = -1; n_rise = 0; wb_total = 0; prev_req = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.wb_en) begin
                wb_total++;
                if (first_wb < 0) first_wb = c;
            end
            if (bus.mem_req && !prev_req) begin
                n_rise++;
                if (n_rise == 2) begin
                    second_req = c;
                    bus.ld_valid = 1'b0;
                end
            end
            prev_req = bus.mem_req;
            bus.mem_ack = bus.mem_req;
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b0;
        bus.mem_ack = 1'b0;
        chk("b2b_first_wb_seen", 32'(first_wb >= 0), 32'd1);
        chk("b2b_wb_total", 32'(wb_total), 32'd2);
`ifdef LDU_BACK2BACK_EN
        chk("b2b_req_after_wb_gap", 32'(second_req - first_wb), 32'd1);
`else
        chk("b2b_req_after_wb_gap", 32'(second_req - first_wb), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
